mioc_dma_arbiter: RTL and testbench
===================================

Name: mioc_dma_arbiter

Overview:
- Arbitrates the ADAM memory bus between the Z80 and the master 6801 DMA engine inside the MIOC.
- On a 6801 DMA request (DMA_N), requests the bus from the Z80 (BUSRQ_N) and waits for BUSAK_N.
- Disables the Z80 address buffers (ADDRBUFEN_N) with guard cycles, then grants the DRAM path to DMA (DMA_GNT). Reverses the sequence on release.
- Includes an acquisition timeout and an error flag.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on the asynchronous DMA_N input (≥2).
- ACQ_TIMEOUT, 64: maximum B_PHI cycles in REQ waiting for BUSAK_N (≥2).
- GUARD_CYCLES, 1: cycles ADDRBUFEN_N is held high around DMA_GNT (≥1).

Ports:
- B_PHI  in  1  Z80 clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- DMA_N  in  1  active-low DMA request from 6801; asynchronous, synchronized internally.
- BUSAK_N  in  1  active-low Z80 bus acknowledge; synchronous to B_PHI, sampled directly.
- BUSRQ_N  out  1  active-low bus request to Z80.
- ADDRBUFEN_N  out  1  active-low Z80 address/control buffer enable; high while DMA owns the bus.
- DMA_GNT  out  1  active-high grant to the DRAM timing/mux logic.
- DMA_ERR  out  1  sticky error flag: acquisition timeout or premature BUSAK_N release.
- STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset (RST_N low at an edge):
  - state=IDLE, BUSRQ_N=1, ADDRBUFEN_N=0, DMA_GNT=0, DMA_ERR=0, counter=0.
  - All sync flops set to 1 (no request).
  - RST_N low mid-operation aborts immediately to these values, regardless of BUSAK_N.
- dma_req: the DMA_N value after SYNC_STAGES flops, inverted. Latency: DMA_N low before edge E0 gives dma_req=1 after edge E0+SYNC_STAGES-1.
- Outputs: registered, a pure decode of the state register, changing on the same edge as the state. No combinational path from any input to any output.
- States (STATE encoding), with outputs BUSRQ_N / ADDRBUFEN_N / DMA_GNT:
  - IDLE(0): 1/0/0.
  - REQ(1): 0/0/0.
  - GUARD_ON(2): 0/1/0.
  - GRANT(3): 0/1/1.
  - GUARD_OFF(4): 0/1/0.
  - RELEASE(5): 1/0/0.
  - ABORT(6): 1/0/0.
- Transitions:
  - IDLE: dma_req && BUSAK_N=1 → REQ; counter cleared; DMA_ERR cleared on this transition. If dma_req && BUSAK_N=0 (stale acknowledge), remain in IDLE.
  - REQ, priority order:
    1. BUSAK_N=0 → GUARD_ON, counter cleared.
    2. Else !dma_req → RELEASE (abandoned request).
    3. Else counter==ACQ_TIMEOUT-1 → ABORT with DMA_ERR=1.
    4. Else counter+1.
    - ABORT is entered exactly ACQ_TIMEOUT edges after REQ entry. A BUSAK_N=0 on that same edge wins.
  - GUARD_ON: counter+1 each edge; at counter==GUARD_CYCLES-1 → GRANT. DMA_GNT rises GUARD_CYCLES edges after ADDRBUFEN_N rises.
  - GRANT:
    - BUSAK_N=1 → GUARD_OFF and DMA_ERR=1 (premature release).
    - Else !dma_req → GUARD_OFF.
    - Counter cleared on exit.
  - GUARD_OFF: counter+1 each edge; at counter==GUARD_CYCLES-1 → RELEASE. ADDRBUFEN_N falls GUARD_CYCLES edges after DMA_GNT falls.
  - RELEASE: BUSAK_N=1 → IDLE; otherwise hold.
  - ABORT: !dma_req && BUSAK_N=1 → IDLE. The 6801 must drop DMA_N before any retry; no re-request loop.
- Edge cases:
  - If dma_req drops while in GUARD_ON, GRANT is still entered, then exited on the next edge.
  - Unused encoding 7 → IDLE on the next edge.
- Invariants (assert in bench):
  - DMA_GNT=1 implies ADDRBUFEN_N=1, BUSRQ_N=0, and BUSAK_N sampled low at GRANT entry.
  - ADDRBUFEN_N=1 implies BUSRQ_N=0.
- Counter width: localparam = clog2(max(ACQ_TIMEOUT, GUARD_CYCLES)+1). Counter saturates, never wraps.

Test Plan (SYNC_STAGES=2, ACQ_TIMEOUT=16, GUARD_CYCLES=2, B_PHI period 300 ns):
- Reset: RST_N low 3 edges with DMA_N=0, BUSAK_N=0 → BUSRQ_N=1, ADDRBUFEN_N=0, DMA_GNT=0, DMA_ERR=0, STATE=0 throughout; after release, REQ is not entered while BUSAK_N=0.
- Normal DMA: DMA_N low before E0 → BUSRQ_N=0 after E0+2. BUSAK_N low at Ea → ADDRBUFEN_N=1 after Ea; DMA_GNT=1 after Ea+2. DMA_N high before Ed → DMA_GNT=0 after Ed+2, ADDRBUFEN_N=0 after Ed+4, BUSRQ_N=1 after Ed+4. BUSAK_N high → STATE=0.
- Timeout: DMA_N low, BUSAK_N held high → ABORT (STATE=6) exactly 16 edges after REQ entry; DMA_ERR=1, BUSRQ_N=1. STATE stays 6 until DMA_N high. A new DMA_N low re-enters REQ and clears DMA_ERR.
- Timeout race: BUSAK_N low on the 16th REQ edge → GUARD_ON (STATE=2), DMA_ERR=0.
- Abandon: DMA_N pulse low for 4 cycles, BUSAK_N high → REQ then RELEASE then IDLE; ADDRBUFEN_N never 1, DMA_GNT never 1.
- Premature BUSAK_N: in GRANT, BUSAK_N goes high → DMA_GNT=0 next edge, DMA_ERR=1, ADDRBUFEN_N=0 two edges later.

Source files
------------

// File: rtl/mioc_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mioc_dma_arbiter
// Description : Hands the ADAM memory bus from the Z80 to the 6801 DMA engine
//               and back, with address-buffer guard cycles and a bus-acquire
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mioc_dma_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int ACQ_TIMEOUT  = 64,
    parameter int GUARD_CYCLES = 1
) (
    input  logic       B_PHI,
    input  logic       RST_N,
    input  logic       DMA_N,
    input  logic       BUSAK_N,
    output logic       BUSRQ_N,
    output logic       ADDRBUFEN_N,
    output logic       DMA_GNT,
    output logic       DMA_ERR,
    output logic [2:0] STATE
);

    localparam int c_cnt_max = (ACQ_TIMEOUT > GUARD_CYCLES) ? ACQ_TIMEOUT : GUARD_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_acq_last   = c_cnt_w'(ACQ_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat    = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_req       = 3'd1;
    localparam logic [2:0] c_st_guard_on  = 3'd2;
    localparam logic [2:0] c_st_grant     = 3'd3;
    localparam logic [2:0] c_st_guard_off = 3'd4;
    localparam logic [2:0] c_st_release   = 3'd5;
    localparam logic [2:0] c_st_abort     = 3'd6;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_err;
    logic                   r_busrq_n;
    logic                   r_addrbufen_n;
    logic                   r_dma_gnt;

    logic                   w_dma_req;
    logic [2:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     w_cnt_inc;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_err_nxt;

    // Reset preloads the chain with "no request" so a held-low DMA_N cannot
    // start a transfer on the first edge after reset.
    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], DMA_N};
        end
    end

    assign w_dma_req = ~r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + c_cnt_one;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_err_nxt   = r_err;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                // A still-low BUSAK_N is left over from the last cycle; wait it out.
                if (w_dma_req && BUSAK_N) begin
                    w_state_nxt = c_st_req;
                    w_err_nxt   = 1'b0;
                end
            end
            c_st_req: begin
                if (!BUSAK_N) begin
                    w_state_nxt = c_st_guard_on;
                    w_cnt_nxt   = '0;
                end else if (!w_dma_req) begin
                    w_state_nxt = c_st_release;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_acq_last) begin
                    w_state_nxt = c_st_abort;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end
            end
            c_st_guard_on: begin
                if (r_cnt == c_guard_last) begin
                    w_state_nxt = c_st_grant;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_grant: begin
                w_cnt_nxt = '0;
                if (BUSAK_N) begin
                    w_state_nxt = c_st_guard_off;
                    w_err_nxt   = 1'b1;
                end else if (!w_dma_req) begin
                    w_state_nxt = c_st_guard_off;
                end
            end
            c_st_guard_off: begin
                if (r_cnt == c_guard_last) begin
                    w_state_nxt = c_st_release;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_release: begin
                w_cnt_nxt = '0;
                if (BUSAK_N) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_abort: begin
                w_cnt_nxt = '0;
                if (!w_dma_req && BUSAK_N) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they flip on the same edge as STATE.
    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_busrq_n     <= 1'b1;
            r_addrbufen_n <= 1'b0;
            r_dma_gnt     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
            r_busrq_n     <= !(w_state_nxt inside {c_st_req, c_st_guard_on, c_st_grant, c_st_guard_off});
            r_addrbufen_n <= (w_state_nxt inside {c_st_guard_on, c_st_grant, c_st_guard_off});
            r_dma_gnt     <= (w_state_nxt == c_st_grant);
        end
    end

    assign BUSRQ_N     = r_busrq_n;
    assign ADDRBUFEN_N = r_addrbufen_n;
    assign DMA_GNT     = r_dma_gnt;
    assign DMA_ERR     = r_err;
    assign STATE       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mioc_dma_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mioc_dma_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               timestamp-based model of the bus hand-over protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mioc_dma_arbiter;

    localparam int SYNC_STAGES  = 2;
    localparam int ACQ_TIMEOUT  = 16;
    localparam int GUARD_CYCLES = 2;

    // {STATE, BUSRQ_N, ADDRBUFEN_N, DMA_GNT, DMA_ERR}
    localparam logic [6:0] E_IDLE = 7'b000_1_0_0_0;
    localparam logic [6:0] E_REQ  = 7'b001_0_0_0_0;
    localparam logic [6:0] E_GON  = 7'b010_0_1_0_0;
    localparam logic [6:0] E_GNT  = 7'b011_0_1_1_0;
    localparam logic [6:0] E_GOFF = 7'b100_0_1_0_0;
    localparam logic [6:0] E_REL  = 7'b101_1_0_0_0;
    localparam logic [6:0] E_ABT  = 7'b110_1_0_0_0;
    localparam logic [6:0] ERR    = 7'b000_0_0_0_1;

    localparam int P_IDLE = 0, P_REQ = 1, P_GON = 2, P_GNT = 3, P_GOFF = 4, P_REL = 5, P_ABT = 6;

    logic       B_PHI   = 1'b0;
    logic       RST_N   = 1'b0;
    logic       DMA_N   = 1'b1;
    logic       BUSAK_N = 1'b1;
    logic       BUSRQ_N;
    logic       ADDRBUFEN_N;
    logic       DMA_GNT;
    logic       DMA_ERR;
    logic [2:0] STATE;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   m_phase = P_IDLE;
    int   m_t     = 0;
    bit   m_err   = 1'b0;
    bit   m_pipe[$];
    logic prev_abuf = 1'b0;

    mioc_dma_arbiter #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACQ_TIMEOUT (ACQ_TIMEOUT),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) dut (
        .B_PHI      (B_PHI),
        .RST_N      (RST_N),
        .DMA_N      (DMA_N),
        .BUSAK_N    (BUSAK_N),
        .BUSRQ_N    (BUSRQ_N),
        .ADDRBUFEN_N(ADDRBUFEN_N),
        .DMA_GNT    (DMA_GNT),
        .DMA_ERR    (DMA_ERR),
        .STATE      (STATE)
    );

    always #150 B_PHI = ~B_PHI;

    function automatic logic [6:0] obs();
        return {STATE, BUSRQ_N, ADDRBUFEN_N, DMA_GNT, DMA_ERR};
    endfunction

    function automatic logic [6:0] m_expect();
        logic [6:0] e;
        case (m_phase)
            P_REQ:   e = E_REQ;
            P_GON:   e = E_GON;
            P_GNT:   e = E_GNT;
            P_GOFF:  e = E_GOFF;
            P_REL:   e = E_REL;
            P_ABT:   e = E_ABT;
            default: e = E_IDLE;
        endcase
        return e | {6'b0, m_err};
    endfunction

    // Protocol model: waits are measured as edges elapsed since entering a
    // phase; the request the arbiter sees is DMA_N from SYNC_STAGES edges ago.
    function automatic void model_step(input logic rst, input logic dn, input logic ak);
        bit req;
        if (!rst) begin
            m_phase = P_IDLE;
            m_err   = 1'b0;
            m_t     = cyc;
            m_pipe.delete();
            repeat (SYNC_STAGES) m_pipe.push_back(1'b1);
            return;
        end
        req = !m_pipe[0];
        case (m_phase)
            P_IDLE: if (req && ak) begin m_phase = P_REQ; m_t = cyc; m_err = 1'b0; end
            P_REQ: begin
                if (!ak)                         begin m_phase = P_GON; m_t = cyc; end
                else if (!req)                   m_phase = P_REL;
                else if (cyc - m_t == ACQ_TIMEOUT) begin m_phase = P_ABT; m_err = 1'b1; end
            end
            P_GON:  if (cyc - m_t == GUARD_CYCLES) m_phase = P_GNT;
            P_GNT: begin
                if (ak)        begin m_phase = P_GOFF; m_t = cyc; m_err = 1'b1; end
                else if (!req) begin m_phase = P_GOFF; m_t = cyc; end
            end
            P_GOFF: if (cyc - m_t == GUARD_CYCLES) m_phase = P_REL;
            P_REL:  if (ak) m_phase = P_IDLE;
            P_ABT:  if (!req && ak) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
        m_pipe.push_back(dn);
        void'(m_pipe.pop_front());
    endfunction

    // One B_PHI cycle: drive inputs, let the edge happen, then check the
    // bus-safety invariants half a cycle later.
    task automatic tick(input logic rst, input logic dn, input logic ak);
        RST_N   = rst;
        DMA_N   = dn;
        BUSAK_N = ak;
        @(posedge B_PHI);
        cyc++;
        model_step(rst, dn, ak);
        @(negedge B_PHI);
        total++;
        if (DMA_GNT && !(ADDRBUFEN_N && !BUSRQ_N)) begin
            bad++;
            $display("FAIL inv_gnt cyc=%0d gnt=%b abuf=%b busrq=%b, need abuf=1 busrq=0", cyc, DMA_GNT, ADDRBUFEN_N, BUSRQ_N);
        end
        total++;
        if (ADDRBUFEN_N && BUSRQ_N) begin
            bad++;
            $display("FAIL inv_abuf cyc=%0d abuf=%b busrq=%b, need busrq=0", cyc, ADDRBUFEN_N, BUSRQ_N);
        end
        if (ADDRBUFEN_N && !prev_abuf) begin
            total++;
            if (ak !== 1'b0) begin
                bad++;
                $display("FAIL inv_ack cyc=%0d busak_n=%b at buffer disable, need 0", cyc, ak);
            end
        end
        prev_abuf = ADDRBUFEN_N;
    endtask

    function automatic logic [9:0] ent(input logic r, input logic d, input logic a, input logic [6:0] e);
        return {r, d, a, e};
    endfunction

    task automatic test_reset();
        logic [9:0] seq[$];
        repeat (3) seq.push_back(ent(0, 0, 0, E_IDLE));
        repeat (5) seq.push_back(ent(1, 0, 0, E_IDLE));
        seq.push_back(ent(1, 0, 1, E_REQ));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL reset step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    task automatic test_normal();
        logic [9:0] seq[$];
        repeat (2) seq.push_back(ent(0, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE));
        repeat (4) seq.push_back(ent(1, 0, 1, E_REQ));
        repeat (2) seq.push_back(ent(1, 0, 0, E_GON));
        repeat (4) seq.push_back(ent(1, 0, 0, E_GNT));
        repeat (2) seq.push_back(ent(1, 1, 0, E_GNT));
        repeat (2) seq.push_back(ent(1, 1, 0, E_GOFF));
        repeat (2) seq.push_back(ent(1, 1, 0, E_REL));
        repeat (2) seq.push_back(ent(1, 1, 1, E_IDLE));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL normal step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] seq[$];
        repeat (2) seq.push_back(ent(0, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE));
        repeat (1 + ACQ_TIMEOUT - 1) seq.push_back(ent(1, 0, 1, E_REQ));
        repeat (5) seq.push_back(ent(1, 0, 1, E_ABT | ERR));
        repeat (2) seq.push_back(ent(1, 1, 1, E_ABT | ERR));
        repeat (2) seq.push_back(ent(1, 1, 1, E_IDLE | ERR));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE | ERR));
        seq.push_back(ent(1, 0, 1, E_REQ));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL timeout step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    task automatic test_timeout_race();
        logic [9:0] seq[$];
        repeat (2) seq.push_back(ent(0, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE));
        repeat (1 + ACQ_TIMEOUT - 1) seq.push_back(ent(1, 0, 1, E_REQ));
        repeat (2) seq.push_back(ent(1, 0, 0, E_GON));
        seq.push_back(ent(1, 0, 0, E_GNT));
        repeat (2) seq.push_back(ent(0, 0, 0, E_IDLE));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL race step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    task automatic test_abandon();
        logic [9:0] seq[$];
        repeat (2) seq.push_back(ent(0, 1, 1, E_IDLE));
        seq.push_back(ent(1, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_REQ));
        repeat (2) seq.push_back(ent(1, 1, 1, E_REQ));
        seq.push_back(ent(1, 1, 1, E_REL));
        repeat (2) seq.push_back(ent(1, 1, 1, E_IDLE));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL abandon step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    task automatic test_premature();
        logic [9:0] seq[$];
        repeat (2) seq.push_back(ent(0, 1, 1, E_IDLE));
        repeat (2) seq.push_back(ent(1, 0, 1, E_IDLE));
        seq.push_back(ent(1, 0, 1, E_REQ));
        repeat (2) seq.push_back(ent(1, 0, 0, E_GON));
        repeat (2) seq.push_back(ent(1, 0, 0, E_GNT));
        repeat (2) seq.push_back(ent(1, 0, 1, E_GOFF | ERR));
        seq.push_back(ent(1, 0, 1, E_REL | ERR));
        seq.push_back(ent(1, 0, 1, E_IDLE | ERR));
        seq.push_back(ent(1, 0, 1, E_REQ));
        foreach (seq[i]) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            total++;
            if (obs() !== seq[i][6:0]) begin
                bad++;
                $display("FAIL premature step=%0d got=%b want=%b", i, obs(), seq[i][6:0]);
            end
        end
    endtask

    // Z80 stand-in answers BUSRQ_N after a random delay, with occasional
    // glitches on BUSAK_N and rare resets to reach the error paths.
    task automatic test_random();
        logic       dn = 1'b1;
        logic       ak = 1'b1;
        logic       rst;
        logic [6:0] want;
        repeat (2) tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            want = m_expect();
            if ($urandom_range(0, 23) == 0) dn = ~dn;
            if ($urandom_range(0, 3) == 0) ak = want[3];
            if ($urandom_range(0, 59) == 0) ak = ~ak;
            rst = ($urandom_range(0, 299) != 0);
            tick(rst, dn, ak);
            want = m_expect();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs(), want);
            end
            if (bad > 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_timeout_race();
        test_abandon();
        test_premature();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
